// File: rtl/capture_pkg.sv
// Shared types and width helpers for the capture writer and its FIFO.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BURST_DEF = 8;
    localparam int BCNT_W    = cnt_w(BURST_DEF);

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO: head always presents the oldest stored word.
module fifo_sync #(
    parameter int DN = 16,
    parameter int FN = 5
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DN-1:0] wdata,
    output logic [DN-1:0] head,
    output logic [FN:0]   level,
    output logic          empty,
    output logic          full
);

    logic [DN-1:0] mem_q [2**FN];
    logic [FN-1:0] wp_q;
    logic [FN-1:0] rp_q;
    logic [FN:0]   lvl_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clkSYS) begin
        if (do_push) begin
            mem_q[wp_q] <= wdata;
        end
    end

    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_q <= rp_q + 1'b1;
            end
            lvl_q <= lvl_q + {{FN{1'b0}}, do_push} - {{FN{1'b0}}, do_pop};
        end
    end

    assign head  = mem_q[rp_q];
    assign level = lvl_q;
    assign empty = (lvl_q == '0);
    assign full  = lvl_q[FN];

endmodule

// File: rtl/capture_writer.sv
// Packs a sample stream into fixed-size write bursts aimed at a circular
// SDRAM region, presented on one arbiter slot.
module capture_writer
    import capture_pkg::*;
#(
    parameter int            AN    = 24,
    parameter int            DN    = 16,
    parameter int            BURST = 8,
    parameter logic [AN-1:0] BASE  = '0,
    parameter int            SN    = 19,
    parameter int            FN    = 5
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          en,
    input  logic          clr,
    input  logic [DN-1:0] din,
    input  logic          din_valid,
    output logic          req,
    output logic          req_wr,
    output logic [AN-1:0] req_addr,
    output logic [DN-1:0] req_data,
    input  logic          req_ack,
    output logic [FN:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          wrap,
    output state_e        dbg_state
);

    localparam int            BW        = cnt_w(BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [FN:0]   BURST_LVL = (FN + 1)'(BURST);
    localparam logic [SN:0]   BURST_INC = (SN + 1)'(BURST);

    state_e        state_q;
    logic          req_q;
    logic          req_wr_q;
    logic          ovf_q;
    logic          wrap_q;
    logic          clr_pend_q;
    logic [SN-1:0] wptr_q;
    logic [BW-1:0] bcnt_q;
    logic [SN:0]   wsum_d;
    logic          push;
    logic          pop;
    logic          drop;

    // Handshake: while req is high, req_addr is stable and req_data shows the
    // FIFO head; a cycle with req & req_ack transfers exactly that word, and
    // the next word appears on req_data the cycle after. req_ack low stalls.
    assign push   = din_valid & en & ~full;
    assign drop   = din_valid & en & full;
    assign pop    = req_q & req_ack;
    assign wsum_d = {1'b0, wptr_q} + BURST_INC;

    fifo_sync #(
        .DN(DN),
        .FN(FN)
    ) u_fifo (
        .clkSYS (clkSYS),
        .n_reset(n_reset),
        .push   (push),
        .pop    (pop),
        .wdata  (din),
        .head   (req_data),
        .level  (level),
        .empty  (empty),
        .full   (full)
    );

    always_ff @(posedge clkSYS) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_wr_q   <= 1'b0;
            ovf_q      <= 1'b0;
            wrap_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            wptr_q     <= '0;
            bcnt_q     <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (clr) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        wptr_q <= '0;
                    end
                    if (level >= BURST_LVL) begin
                        state_q  <= REQ;
                        req_q    <= 1'b1;
                        req_wr_q <= 1'b1;
                        bcnt_q   <= '0;
                    end
                end
                REQ: begin
                    if (req_ack && bcnt_q == LAST_BEAT) begin
                        state_q    <= DONE;
                        req_q      <= 1'b0;
                        req_wr_q   <= 1'b0;
                        bcnt_q     <= '0;
                        clr_pend_q <= 1'b0;
                        // A clear seen during the burst wins over the advance.
                        if (clr || clr_pend_q) begin
                            wptr_q <= '0;
                        end else begin
                            wptr_q <= wsum_d[SN-1:0];
                            wrap_q <= wsum_d[SN];
                        end
                    end else begin
                        if (req_ack) begin
                            bcnt_q <= bcnt_q + BW'(1);
                        end
                        if (clr) begin
                            clr_pend_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clr) begin
                        wptr_q <= '0;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req       = req_q;
    assign req_wr    = req_wr_q;
    assign req_addr  = BASE + AN'(wptr_q);
    assign overflow  = ovf_q;
    assign wrap      = wrap_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer with a reference FIFO/pointer model.
module tb_capture_writer;
    import capture_pkg::*;

    localparam int          AN    = 24;
    localparam int          DN    = 16;
    localparam int          BURST = 8;
    localparam int          SN    = 4;
    localparam int          FN    = 5;
    localparam logic [23:0] BASE  = 24'h000040;
    localparam int          DEPTH = 32;
    localparam int          REGION = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_reset = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [DN-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          req_ack = 1'b0;
    logic          req;
    logic          req_wr;
    logic [AN-1:0] req_addr;
    logic [DN-1:0] req_data;
    logic [FN:0]   level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          wrap;
    state_e        dbg_state;

    capture_writer #(
        .AN(AN), .DN(DN), .BURST(BURST), .BASE(BASE), .SN(SN), .FN(FN)
    ) dut (
        .clkSYS   (clk),
        .n_reset  (n_reset),
        .en       (en),
        .clr      (clr),
        .din      (din),
        .din_valid(din_valid),
        .req      (req),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_ack  (req_ack),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .wrap     (wrap),
        .dbg_state(dbg_state)
    );

    // ---------------- check ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [DN-1:0] exp_q[$];
    logic [23:0]   addr_log[$];
    int            mdl_level = 0;
    int            mdl_wptr  = 0;
    int            mdl_beats = 0;
    bit            mdl_pend  = 1'b0;
    bit            mdl_ovf   = 1'b0;
    bit            mdl_wrap  = 1'b0;
    bit            fin1 = 1'b0;
    bit            fin2 = 1'b0;
    bit            prev_req = 1'b0;
    bit            mon_en = 1'b0;
    int            ack_cnt = 0;
    int            wrap_cnt = 0;

    always @(negedge clk) begin
        bit m_push;
        bit m_pop;
        bit nxt_wrap;
        bit nxt_fin;
        if (mon_en) begin
            check("level", level, mdl_level);
            check("empty", empty, mdl_level == 0);
            check("full", full, mdl_level == DEPTH);
            check("overflow", overflow, mdl_ovf);
            check("wrap", wrap, mdl_wrap);
            check("req_wr", req_wr, req);
            if (fin1) check("gap1", req, 0);
            if (fin2) check("gap2", req, 0);
            if (wrap) wrap_cnt++;
            if (req && !prev_req) addr_log.push_back(req_addr);
        end
        prev_req = req;
        nxt_wrap = 1'b0;
        nxt_fin  = 1'b0;
        if (!n_reset) begin
            exp_q.delete();
            mdl_level = 0;
            mdl_wptr  = 0;
            mdl_beats = 0;
            mdl_pend  = 1'b0;
            mdl_ovf   = 1'b0;
        end else if (mon_en) begin
            m_push = din_valid && en && (mdl_level < DEPTH);
            m_pop  = req && req_ack;
            if (m_pop) begin
                ack_cnt++;
                check("req_addr", req_addr, BASE + mdl_wptr);
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("req_data", req_data, exp_q.pop_front());
            end
            if (m_push) exp_q.push_back(din);
            if (din_valid && en && !m_push) mdl_ovf = 1'b1;
            if (clr) mdl_ovf = 1'b0;
            mdl_level = mdl_level + int'(m_push) - int'(m_pop);
            if (m_pop && mdl_beats == BURST - 1) begin
                mdl_beats = 0;
                nxt_fin = 1'b1;
                if (mdl_pend || clr) begin
                    mdl_wptr = 0;
                end else begin
                    nxt_wrap = (mdl_wptr + BURST) >= REGION;
                    mdl_wptr = (mdl_wptr + BURST) % REGION;
                end
                mdl_pend = 1'b0;
            end else begin
                if (m_pop) mdl_beats++;
                if (clr && req) mdl_pend = 1'b1;
                else if (clr) mdl_wptr = 0;
            end
        end
        mdl_wrap = nxt_wrap;
        fin2 = fin1 && n_reset;
        fin1 = nxt_fin;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        n_reset   = 1'b0;
        din_valid = 1'b0;
        req_ack   = 1'b0;
        clr       = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic push_word(input logic [DN-1:0] d);
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic push_n(input logic [DN-1:0] start, input int n);
        for (int i = 0; i < n; i++) push_word(start + DN'(i));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_acks(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && ack_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, ack_cnt, target);
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !req; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, req, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int busy;
        do_reset(2);
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_req_wr", req_wr, 0);
        check("rst_overflow", overflow, 0);
        check("rst_wrap", wrap, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_addr", req_addr, BASE);
        check("rst_state", dbg_state, IDLE);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // one burst of 1..8
        en = 1'b1;
        push_n(16'h0001, 8);
        @(negedge clk);
        check("lat_req_low", req, 0);
        @(negedge clk);
        check("lat_req_high", req, 1);
        check("t1_addr", req_addr, BASE);
        @(posedge clk);
        #1;
        base = ack_cnt;
        req_ack = 1'b1;
        wait_acks("t1_acks", base + 8, 40);
        req_ack = 1'b0;
        @(negedge clk);
        check("t1_level", level, 0);
        check("t1_req_idle", req, 0);

        // fill to full, drop, clear pending during REQ, then drain
        do_reset(1);
        push_n(16'h0100, 32);
        @(negedge clk);
        check("t2_full", full, 1);
        check("t2_level32", level, 32);
        check("t2_no_ovf", overflow, 0);
        push_word(16'h01ff);
        @(negedge clk);
        check("t2_ovf", overflow, 1);
        check("t2_level_hold", level, 32);
        pulse_clr();
        @(negedge clk);
        check("t2_clr_ovf", overflow, 0);
        @(posedge clk);
        #1;
        base = ack_cnt;
        req_ack = 1'b1;
        wait_acks("t2_drain", base + 32, 200);
        req_ack = 1'b0;
        @(negedge clk);
        check("t2_empty", empty, 1);

        // three bursts over a 16-word region
        do_reset(1);
        addr_log.delete();
        wrap_cnt = 0;
        base = ack_cnt;
        req_ack = 1'b1;
        push_n(16'h0300, 24);
        wait_acks("t3_acks", base + 24, 200);
        req_ack = 1'b0;
        @(negedge clk);
        check("t3_nbursts", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("t3_addr0", addr_log[0], BASE);
            check("t3_addr1", addr_log[1], BASE + 24'd8);
            check("t3_addr2", addr_log[2], BASE);
        end
        check("t3_wrap_once", wrap_cnt, 1);

        // ack toggling while pushing
        do_reset(1);
        base = ack_cnt;
        for (int i = 0; i < 16; i++) begin
            din       = 16'h0400 + DN'(i);
            din_valid = 1'b1;
            req_ack   = i[0];
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        for (int i = 0; i < 200 && ack_cnt < base + 16; i++) begin
            req_ack = ~req_ack;
            @(posedge clk);
            #1;
        end
        check("t4_acks", ack_cnt, base + 16);
        req_ack = 1'b0;
        @(negedge clk);
        check("t4_level", level, 0);

        // reset after three beats
        do_reset(1);
        push_n(16'h0600, 8);
        wait_req("t5_req", 20);
        base = ack_cnt;
        req_ack = 1'b1;
        wait_acks("t5_three", base + 3, 20);
        n_reset = 1'b0;
        req_ack = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(negedge clk);
        check("t5_req", req, 0);
        check("t5_level", level, 0);
        check("t5_empty", empty, 1);
        push_n(16'h0700, 8);
        wait_req("t5_req2", 20);
        check("t5_addr", req_addr, BASE);
        base = ack_cnt;
        req_ack = 1'b1;
        wait_acks("t5_acks", base + 8, 40);
        req_ack = 1'b0;

        // partial fill, en low, then resume
        do_reset(1);
        push_n(16'h0500, 5);
        en = 1'b0;
        push_n(16'h0eee, 3);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req) busy++;
        end
        check("t6_no_req", busy, 0);
        check("t6_level5", level, 5);
        @(posedge clk);
        #1;
        en = 1'b1;
        push_n(16'h0505, 3);
        base = ack_cnt;
        req_ack = 1'b1;
        wait_acks("t6_acks", base + 8, 60);
        req_ack = 1'b0;
        @(negedge clk);
        check("t6_sb_drained", exp_q.size(), 0);
        check("t6_empty", empty, 1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
